// File: rtl/bcd2bin_pkg.sv
// bcd2bin_pkg: shared types and constants for the BCD2BIN scheduler.
// FSM state enum, BCD digit limit, watchdog counter width helper.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/bcd2bin_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching up from ptr.
// req/ptr in; one-hot gnt, binary gnt_idx and any out.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int j;

    // Walk offsets downward so the lowest offset from ptr wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[j]) begin
                gnt_idx = IW'(j);
                any     = 1'b1;
            end
        end
        gnt = '0;
        if (any) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/bcd2bin_sched.sv
// bcd2bin_sched: shares one BCD2BIN converter among N_REQ requesters.
// in_REQ/in_DEC_BUS/in_UND_BUS from clients; out_ACK/out_BIN/out_ERR back;
// out_DEC/out_UND/out_INIT to converter, in_BIN/in_DONE from it.
module bcd2bin_sched
    import bcd2bin_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   in_REQ,
    input  logic [4*N_REQ-1:0] in_DEC_BUS,
    input  logic [4*N_REQ-1:0] in_UND_BUS,
    output logic [N_REQ-1:0]   out_ACK,
    output logic [7:0]         out_BIN,
    output logic               out_ERR,
    output logic               out_BUSY,
    output logic [3:0]         out_DEC,
    output logic [3:0]         out_UND,
    output logic               out_INIT,
    input  logic [7:0]         in_BIN,
    input  logic               in_DONE
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = cnt_width(TIMEOUT);

    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    gnt_idx_q;
    logic [N_REQ-1:0] gnt_q;
    logic             mask_vld;
    logic [CW-1:0]    cnt;
    logic [3:0]       dec_q;
    logic [3:0]       und_q;
    logic [7:0]       res_q;
    logic             err_q;

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic [3:0]       sel_dec;
    logic [3:0]       sel_und;

    // gnt_q still holds the last served requester during the mask cycle.
    assign cand = in_REQ & ~(mask_vld ? gnt_q : '0);

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req     (cand),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    assign sel_dec = in_DEC_BUS[{arb_idx, 2'b00} +: 4];
    assign sel_und = in_UND_BUS[{arb_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_idx_q <= '0;
            gnt_q     <= '0;
            mask_vld  <= 1'b0;
            cnt       <= '0;
            dec_q     <= '0;
            und_q     <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    mask_vld <= 1'b0;
                    if (arb_any) begin
                        gnt_idx_q <= arb_idx;
                        gnt_q     <= arb_gnt;
                        dec_q     <= sel_dec;
                        und_q     <= sel_und;
                        if (sel_dec > BCD_MAX || sel_und > BCD_MAX) begin
                            res_q <= '0;
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            state <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (in_DONE) begin
                        res_q <= in_BIN;
                        err_q <= 1'b0;
                        state <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (gnt_idx_q == IW'(N_REQ - 1)) rr_ptr <= '0;
                    else rr_ptr <= gnt_idx_q + IW'(1);
                    mask_vld <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // res_q only changes on entry to RESP, so out_BIN holds between ACKs.
    assign out_ACK  = (state == RESP) ? gnt_q : '0;
    assign out_BIN  = res_q;
    assign out_ERR  = (state == RESP) & err_q;
    assign out_BUSY = (state != IDLE);
    assign out_INIT = (state == LAUNCH);
    assign out_DEC  = dec_q;
    assign out_UND  = und_q;

endmodule

// File: doc/bcd2bin_sched.md
# bcd2bin_sched

Scheduler that shares one BCD2BIN converter among `N_REQ` requesters. Each requester presents a two-digit BCD value (tens and units). The block arbitrates round-robin, validates the digits, launches the converter with a one-cycle `INIT`, and waits for `DONE` under a watchdog. It then returns the 8-bit binary result to the granted requester with a one-cycle acknowledge. It sits between the application clients and the single shared converter instance.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 16, maximum cycles spent in WAIT before the conversion is aborted (≥2)

Ports:
- `clk` in 1: system clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `in_REQ` in N_REQ: level request per requester; held with its data until that requester's ACK
- `in_DEC_BUS` in 4*N_REQ: tens digit of requester i at [4i+3:4i]
- `in_UND_BUS` in 4*N_REQ: units digit of requester i at [4i+3:4i]
- `out_ACK` out N_REQ: one-hot, one-cycle completion pulse
- `out_BIN` out 8: result; valid while any `out_ACK` is high, otherwise holds its last value
- `out_ERR` out 1: valid with ACK; 1 = invalid BCD or timeout
- `out_BUSY` out 1: high in every state except IDLE
- `out_DEC`, `out_UND` out 4 each: digits to the converter, stable from LAUNCH through WAIT
- `out_INIT` out 1: converter start, one-cycle pulse
- `in_BIN` in 8: converter result
- `in_DONE` in 1: converter done

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- **IDLE**
  - Compute candidates as `in_REQ` & ~mask. `mask` blocks only the requester served in the immediately preceding RESP, and only for this one IDLE cycle.
  - If there are no candidates, stay in IDLE.
  - Otherwise grant the first candidate searching upward from `rr_ptr` with wrap-around, and latch its digits into the dec/und registers.
  - If either digit is >9, set the error flag and go to RESP. Otherwise go to LAUNCH.
- **LAUNCH**: `out_INIT`=1 for exactly this cycle. Clear the watchdog count. Go to WAIT.
- **WAIT**
  - If `in_DONE`=1: capture `in_BIN` into the result register, set err=0, go to RESP.
  - Else if count == TIMEOUT-1: set result=0 and err=1, go to RESP.
  - Else increment count.
  - If `in_DONE` and the timeout condition occur in the same cycle, DONE wins.
- **RESP**
  - Drive `out_ACK[grant]`=1, `out_BIN`=result, `out_ERR`=err.
  - Set `rr_ptr` = (grant+1) mod N_REQ and mask = grant.
  - Go to IDLE.
- **Invalid BCD**: `out_BIN`=0, `out_ERR`=1. The converter is never started.
- `in_DONE` outside WAIT is ignored. `in_REQ` changes outside IDLE are ignored, because the data was latched at grant.
- **Reset mid-operation**: every register clears immediately and `out_INIT` drops. The converter shares the same `rst` net, so no partial conversion survives.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, mask=none, count=0.
  - Outputs: `out_ACK`=0, `out_BIN`=0, `out_ERR`=0, `out_BUSY`=0, `out_INIT`=0, `out_DEC`=0, `out_UND`=0.
- Cycle numbering for a valid request: grant at cycle 0 (IDLE), `out_INIT` at cycle 1, WAIT begins at cycle 2.
  - `in_DONE` seen at cycle k → ACK at cycle k+1.
  - Minimum total is 4 cycles (DONE at cycle 2, ACK at 3).
- Invalid BCD: grant at cycle 0, ACK at cycle 1.
- Timeout: WAIT occupies cycles 2..TIMEOUT+1, ACK with err at cycle TIMEOUT+2.
- All outputs are registered or decoded purely from state. There is no combinational path from `in_*` to `out_*`.
- A requester must drop `in_REQ` in the cycle after its ACK; the mask covers that cycle. If `in_REQ` is still high afterwards, it is treated as a new request.

## Structure
- Package `bcd2bin_pkg`: state enum (IDLE/LAUNCH/WAIT/RESP), constant `BCD_MAX`=9, width helper for the watchdog count ($clog2(TIMEOUT)).
- One sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req`, `ptr`. Outputs: one-hot `gnt`, binary `gnt_idx`, `any`.
  - Purely combinational.
- FSM, latches and watchdog live in the top level.

## Test plan
- **Single valid request**: REQ[0] with DEC=4, UND=2; converter model returns 42 after 8 cycles → `out_INIT` at cycle 1, `out_DEC`=4 and `out_UND`=2 held through WAIT, ACK[0] with `out_BIN`=0x2A and ERR=0, BUSY low afterwards.
- **Round-robin fairness**: REQ[3:0]=4'b1111 held continuously with distinct digits → ACK order 0,1,2,3,0, each with its correct result; `rr_ptr` wraps from 3 to 0.
- **Invalid BCD**: REQ[2] with DEC=4'hA, UND=3 → ACK[2] at cycle 1 with BIN=0 and ERR=1; `out_INIT` never asserted.
- **Timeout**: TIMEOUT=16, converter never asserts DONE → ACK at cycle 18 with ERR=1 and BIN=0. Separately, DONE arriving exactly at count 15 → ERR=0 with the captured result.
- **Reset mid-WAIT**: drop `rst` during WAIT → all outputs zero asynchronously, state IDLE, `rr_ptr`=0; after release, a pending REQ[1] is granted cleanly.
- **Mask / held REQ**: REQ[0] kept high after its ACK with no other requesters → no re-grant in the next cycle; re-granted the cycle after that.
